// File: rtl/disp_demux.sv
// Receive side of a 3-digit multiplexed seven-segment bus: synchronizes the
// active-low enables and segment bus, waits for stable dwells and rebuilds per-digit words.
module disp_demux #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STABLE    = 4,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sseg_in,
  input  logic [2:0]       en_in,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [2:0]       digit_valid,
  output logic             frame_done,
  output logic             err_multi,
  output logic             timeout
);

  localparam int unsigned SAMP_W = WIDTH + 3;
  localparam int unsigned CNT_W  = (STABLE > 2) ? $clog2(STABLE) : 1;
  localparam logic [CNT_W-1:0]     STAB_MAX = CNT_W'(STABLE - 1);
  localparam logic [SAMP_W-1:0]    SAMP_IDLE = {3'b111, {WIDTH{1'b0}}};

  // Synchronizers
  logic [2:0]       en_meta_q, en_meta_d, en_sync_q, en_sync_d;
  logic [WIDTH-1:0] sseg_meta_q, sseg_meta_d, sseg_sync_q, sseg_sync_d;

  // Dwell tracking
  logic [SAMP_W-1:0] samp_prev_q, samp_prev_d;
  logic [CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic              captured_q, captured_d;

  // Frame and timeout tracking
  logic [2:0]           seen_q, seen_d;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;

  // Output registers
  logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
  logic [2:0]       digit_valid_q, digit_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             err_multi_q, err_multi_d;
  logic             timeout_q, timeout_d;

  // Combinational helpers
  logic [SAMP_W-1:0] samp_s;
  logic              same_s;
  logic              qualified;
  logic [2:0]        dwell_en;
  logic [WIDTH-1:0]  dwell_sseg;
  logic [2:0]        wr_en;
  logic              illegal;
  logic              capture;
  logic [2:0]        seen_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_meta_q     <= 3'b111;
      en_sync_q     <= 3'b111;
      sseg_meta_q   <= '0;
      sseg_sync_q   <= '0;
      samp_prev_q   <= SAMP_IDLE;
      stab_cnt_q    <= '0;
      captured_q    <= 1'b0;
      seen_q        <= '0;
      to_cnt_q      <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      digit_valid_q <= '0;
      frame_done_q  <= 1'b0;
      err_multi_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      en_meta_q     <= en_meta_d;
      en_sync_q     <= en_sync_d;
      sseg_meta_q   <= sseg_meta_d;
      sseg_sync_q   <= sseg_sync_d;
      samp_prev_q   <= samp_prev_d;
      stab_cnt_q    <= stab_cnt_d;
      captured_q    <= captured_d;
      seen_q        <= seen_d;
      to_cnt_q      <= to_cnt_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      digit_valid_q <= digit_valid_d;
      frame_done_q  <= frame_done_d;
      err_multi_q   <= err_multi_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    en_meta_d   = en_in;
    en_sync_d   = en_meta_q;
    sseg_meta_d = sseg_in;
    sseg_sync_d = sseg_meta_q;

    samp_s      = {en_sync_q, sseg_sync_q};
    same_s      = (samp_s == samp_prev_q);
    samp_prev_d = samp_s;

    // The previous sample is the one that completed the dwell; decoding it
    // keeps a change landing on the qualifying cycle out of the captured word.
    qualified  = (stab_cnt_q == STAB_MAX) && !captured_q;
    dwell_en   = samp_prev_q[SAMP_W-1 -: 3];
    dwell_sseg = samp_prev_q[WIDTH-1:0];

    if (same_s) begin
      stab_cnt_d = (stab_cnt_q == STAB_MAX) ? STAB_MAX : stab_cnt_q + CNT_W'(1);
      captured_d = captured_q | qualified;
    end else begin
      stab_cnt_d = '0;
      captured_d = 1'b0;
    end

    wr_en   = '0;
    illegal = 1'b0;
    if (qualified) begin
      case (dwell_en)
        3'b110:  wr_en = 3'b001;
        3'b101:  wr_en = 3'b010;
        3'b011:  wr_en = 3'b100;
        3'b111:  wr_en = 3'b000;
        default: illegal = 1'b1;
      endcase
    end
    capture = |wr_en;

    out0_d = wr_en[0] ? dwell_sseg : out0_q;
    out1_d = wr_en[1] ? dwell_sseg : out1_q;
    out2_d = wr_en[2] ? dwell_sseg : out2_q;
    digit_valid_d = digit_valid_q | wr_en;
    err_multi_d   = illegal;

    // A completed frame pulses once and restarts the seen mask; a repeated digit restarts it too.
    frame_done_d = (seen_q == 3'b111);
    seen_base    = frame_done_d ? 3'b000 : seen_q;
    seen_d       = seen_base;
    if (capture) begin
      seen_d = (|(seen_base & wr_en)) ? wr_en : (seen_base | wr_en);
    end

    to_cnt_d  = capture ? '0 : ((&to_cnt_q) ? to_cnt_q : to_cnt_q + TIMEOUT_W'(1));
    timeout_d = !capture && (&to_cnt_d);
    if (timeout_d) begin
      digit_valid_d = '0;
      seen_d        = '0;
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign digit_valid = digit_valid_q;
  assign frame_done  = frame_done_q;
  assign err_multi   = err_multi_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_disp_demux.sv
// Bench for disp_demux: directed vector table, hand-written corner sequences and
// random dwells checked every cycle against a pin-level behavioural model.
module tb_disp_demux;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STABLE = 4;
  localparam int unsigned TW     = 6;
  localparam int          TO_MAX = (1 << TW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] sseg_in = '0;
  logic [2:0]       en_in = 3'b111;
  logic [WIDTH-1:0] out0, out1, out2;
  logic [2:0]       digit_valid;
  logic             frame_done, err_multi, timeout;

  disp_demux #(.WIDTH(WIDTH), .STABLE(STABLE), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .sseg_in(sseg_in), .en_in(en_in),
    .out0(out0), .out1(out1), .out2(out2), .digit_valid(digit_valid),
    .frame_done(frame_done), .err_multi(err_multi), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt, err_cnt;

  // Model: pin history (newest first), run length of the dwell that completes three edges later
  typedef logic [WIDTH+2:0] samp_t;
  samp_t      hist[$];
  int         run;
  logic [7:0] m_out[3];
  logic [2:0] m_valid, m_seen;
  logic       m_fd, m_err, m_to;
  int         m_tc;

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < 4; i++) hist.push_front({3'b111, 8'h00});
    run = 0;
    for (int i = 0; i < 3; i++) m_out[i] = '0;
    m_valid = '0; m_seen = '0; m_fd = 1'b0; m_err = 1'b0; m_to = 1'b0; m_tc = 0;
  endfunction

  function automatic void model_edge(samp_t p);
    samp_t v, pv;
    logic [2:0] en;
    logic [7:0] sg;
    logic cap;
    int d;
    hist.push_front(p);
    v  = hist[3];
    pv = hist[4];
    void'(hist.pop_back());
    run = (v == pv) ? run + 1 : 1;
    en  = v[10:8];
    sg  = v[7:0];
    cap = 1'b0;
    m_err = 1'b0;
    m_fd = (m_seen == 3'b111);
    if (m_fd) m_seen = 3'b000;
    if (run == STABLE) begin
      case (en)
        3'b110:  d = 0;
        3'b101:  d = 1;
        3'b011:  d = 2;
        3'b111:  d = -1;
        default: begin d = -1; m_err = 1'b1; end
      endcase
      if (d >= 0) begin
        m_out[d] = sg;
        m_valid[d] = 1'b1;
        if (m_seen[d]) m_seen = 3'(1 << d);
        else m_seen[d] = 1'b1;
        cap = 1'b1;
      end
    end
    if (cap) m_tc = 0;
    else if (m_tc < TO_MAX) m_tc++;
    m_to = (m_tc == TO_MAX);
    if (m_to) begin
      m_valid = '0;
      m_seen  = '0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given pins, then compare every output against the model
  task automatic step(input logic [2:0] en, input logic [7:0] sg);
    en_in = en;
    sseg_in = sg;
    @(posedge clk);
    model_edge({en, sg});
    #1;
    checks++;
    if ({out0, out1, out2, digit_valid, frame_done, err_multi, timeout} !==
        {m_out[0], m_out[1], m_out[2], m_valid, m_fd, m_err, m_to}) begin
      errors++;
      $display("FAIL model t=%0t: got out=%h/%h/%h dv=%b fd=%b em=%b to=%b, expected out=%h/%h/%h dv=%b fd=%b em=%b to=%b",
               $time, out0, out1, out2, digit_valid, frame_done, err_multi, timeout,
               m_out[0], m_out[1], m_out[2], m_valid, m_fd, m_err, m_to);
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (err_multi === 1'b1) err_cnt++;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " outs"}, {out0, out1, out2}, 0);
    chk({name, " flags"}, {digit_valid, frame_done, err_multi, timeout}, 0);
  endtask

  typedef struct {
    logic [2:0] en;
    logic [7:0] sseg;
    int         cycles;
    logic [7:0] e0, e1, e2;
    logic [2:0] ev;
    int         efd;
    int         eerr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n;
    bit found;
    bit prev_to;

    vecs[0]  = '{3'b111, 8'h00, 20, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0};
    vecs[1]  = '{3'b110, 8'h3F, 10, 8'h3F, 8'h00, 8'h00, 3'b001, 0, 0};
    vecs[2]  = '{3'b101, 8'h06, 10, 8'h3F, 8'h06, 8'h00, 3'b011, 0, 0};
    vecs[3]  = '{3'b011, 8'h5B, 10, 8'h3F, 8'h06, 8'h5B, 3'b111, 1, 0};
    vecs[4]  = '{3'b110, 8'h3F, 10, 8'h3F, 8'h06, 8'h5B, 3'b111, 0, 0};
    vecs[5]  = '{3'b101, 8'hFF,  2, 8'h3F, 8'h06, 8'h5B, 3'b111, 0, 0};
    vecs[6]  = '{3'b110, 8'h3F, 10, 8'h3F, 8'h06, 8'h5B, 3'b111, 0, 0};
    vecs[7]  = '{3'b100, 8'hAA, 10, 8'h3F, 8'h06, 8'h5B, 3'b111, 0, 1};
    vecs[8]  = '{3'b111, 8'h00, 10, 8'h3F, 8'h06, 8'h5B, 3'b111, 0, 0};
    vecs[9]  = '{3'b100, 8'hAA, 10, 8'h3F, 8'h06, 8'h5B, 3'b111, 0, 1};
    vecs[10] = '{3'b110, 8'h11, 10, 8'h11, 8'h06, 8'h5B, 3'b111, 0, 0};
    vecs[11] = '{3'b101, 8'h22, 10, 8'h11, 8'h22, 8'h5B, 3'b111, 0, 0};
    vecs[12] = '{3'b110, 8'h33, 10, 8'h33, 8'h22, 8'h5B, 3'b111, 0, 0};
    vecs[13] = '{3'b011, 8'h44, 10, 8'h33, 8'h22, 8'h44, 3'b111, 0, 0};

    // Reset with random bus activity
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      en_in = 3'($urandom);
      sseg_in = 8'($urandom);
      @(posedge clk);
      #1;
      chk_all_zero($sformatf("reset%0d", i));
    end
    en_in = 3'b111;
    sseg_in = 8'h00;
    rst = 1'b1;

    // Directed vector table: frame, glitch, illegal enables, sequence restart
    for (int i = 0; i < 14; i++) begin
      fd_cnt = 0;
      err_cnt = 0;
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].en, vecs[i].sseg);
      chk($sformatf("row%0d out0", i), out0, vecs[i].e0);
      chk($sformatf("row%0d out1", i), out1, vecs[i].e1);
      chk($sformatf("row%0d out2", i), out2, vecs[i].e2);
      chk($sformatf("row%0d digit_valid", i), digit_valid, vecs[i].ev);
      chk($sformatf("row%0d frame_done pulses", i), fd_cnt, vecs[i].efd);
      chk($sformatf("row%0d err_multi pulses", i), err_cnt, vecs[i].eerr);
    end

    // Capture latency counted from the first edge that samples the new pins
    n = 0; found = 0;
    while (!found && n < 20) begin
      step(3'b110, 8'h55);
      n++;
      if (out0 == 8'h55) found = 1;
    end
    chk("capture latency", n - 1, STABLE + 2);

    // Timeout after 2^TW-1 idle cycles
    n = 0; found = 0;
    while (!found && n < 100) begin
      step(3'b111, 8'h00);
      n++;
      if (timeout) found = 1;
    end
    chk("timeout delay", n, TO_MAX);
    chk("timeout digit_valid", digit_valid, 3'b000);
    chk("timeout out0 kept", out0, 8'h55);
    while (n < 70) begin
      step(3'b111, 8'h00);
      n++;
    end
    chk("timeout held", timeout, 1);

    // Next capture clears timeout on the same edge that writes the word
    n = 0; found = 0; prev_to = timeout;
    while (!found && n < 20) begin
      prev_to = timeout;
      step(3'b101, 8'h66);
      n++;
      if (out1 == 8'h66) found = 1;
    end
    chk("timeout before capture", prev_to, 1);
    chk("timeout clear", timeout, 0);
    chk("post-timeout digit_valid", digit_valid, 3'b010);
    chk("post-timeout out0", out0, 8'h55);
    for (int c = 0; c < 5; c++) step(3'b101, 8'h66);

    // Reset in the middle of a dwell
    step(3'b011, 8'h77);
    step(3'b011, 8'h77);
    rst = 1'b0;
    model_reset();
    #1;
    chk_all_zero("mid-dwell reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < STABLE + 2; c++) step(3'b011, 8'h77);
    chk("post-reset early out2", out2, 8'h00);
    chk("post-reset early valid", digit_valid, 3'b000);
    step(3'b011, 8'h77);
    chk("post-reset out2", out2, 8'h77);
    chk("post-reset valid", digit_valid, 3'b100);

    // Random dwells against the model
    for (int k = 0; k < 300; k++) begin
      int kind, dur;
      logic [2:0] en;
      logic [7:0] sg;
      kind = int'($urandom_range(0, 11));
      sg = 8'($urandom);
      dur = int'($urandom_range(1, 2 * STABLE + 2));
      if (kind < 6) begin
        case ($urandom_range(0, 2))
          0: en = 3'b110;
          1: en = 3'b101;
          default: en = 3'b011;
        endcase
      end else if (kind < 8) begin
        en = 3'b111;
      end else if (kind < 10) begin
        en = 3'($urandom);
      end else if (kind == 10) begin
        en = 3'b111;
        dur = int'($urandom_range(55, 75));
      end else begin
        en = 3'($urandom);
        dur = STABLE;
      end
      for (int c = 0; c < dur; c++) step(en, sg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_demux.md
Name: disp_demux

Overview:
- Receive side of the 3-digit multiplexed seven-segment bus: active-low digit enables plus a shared segment bus.
- Samples the bus, rejects glitches and illegal enable patterns, and rebuilds the three per-digit segment words into stable registers.
- Used for loopback self-test of the display path and for capturing an external multiplexed display.
- Runs on the system clock; inputs are asynchronous to it.

Parameters:
- WIDTH, 8, segment bus width per digit.
- STABLE, 4, consecutive identical synchronized samples needed before capture; legal range >= 2.
- TIMEOUT_W, 20, timeout counter width; timeout fires after 2^TIMEOUT_W - 1 cycles with no capture.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- sseg_in  input  WIDTH  multiplexed segment bus, asynchronous.
- en_in  input  3  digit enables, active-low, asynchronous.
- out0  output  WIDTH  captured word for digit 0.
- out1  output  WIDTH  captured word for digit 1.
- out2  output  WIDTH  captured word for digit 2.
- digit_valid  output  3  bit i set once out_i holds a capture since reset or timeout.
- frame_done  output  1  one-cycle pulse when all three digits have been captured.
- err_multi  output  1  one-cycle pulse when a stable illegal enable pattern is seen.
- timeout  output  1  level; bus inactive for too long.

Behaviour:
- Reset (async, rst=0):
  - out0/1/2=0, digit_valid=000, frame_done=0, err_multi=0, timeout=0.
  - Synchronizer stages: en=111, sseg=0. Stability counter, captured flag, seen mask and timeout counter all 0.
- Synchronization: two flops each on en_in and sseg_in. Synchronized sample s = {en_s, sseg_s}.
- Stability:
  - Register previous s. If s == previous, increment stab_cnt, saturating at STABLE-1. Otherwise clear stab_cnt to 0 and clear the captured flag.
  - A dwell is qualified when stab_cnt == STABLE-1 and the captured flag is 0. Only one action per dwell; the captured flag is set on that action.
- Decode on a qualified dwell:
  - en_s=110: write out0 <= sseg_s.
  - en_s=101: write out1 <= sseg_s.
  - en_s=011: write out2 <= sseg_s.
  - Each write sets the matching digit_valid bit and seen bit.
  - en_s=111 (blank): no action.
  - Any pattern with two or more zeros: err_multi pulses for 1 cycle; no output change.
- Latency: pins held constant from edge t0 produce the updated out_i, visible from cycle t0+STABLE+2. A pin change shorter than STABLE cycles after synchronization produces no capture.
- Frame tracking:
  - seen mask (3 bits), initially 000.
  - Capture of digit d with seen[d]=0: set seen[d].
  - Capture of digit d with seen[d]=1: seen <= one-hot(d). This is a sequence restart; no pulse.
  - When seen reaches 111: frame_done=1 in the following cycle only, and seen clears to 000 at that edge.
- Timeout:
  - to_cnt increments every cycle without a capture and clears on any capture. It saturates at all-ones.
  - While saturated: timeout=1, digit_valid=000, seen=000. out0/1/2 hold their last values.
  - The next capture clears timeout in the same edge that writes the output.
  - Capture and saturation in the same cycle: capture wins.
- Reset mid-dwell discards partial stability and seen state; there is no capture on the first post-reset cycles until STABLE identical samples have accumulated.
- All outputs are registered; there are no combinational paths from inputs.

Test Plan:
- Reset: assert rst=0 with random bus activity -> all outputs 0. Release rst with en_in=111 for 20 cycles -> outputs stay 0, no pulses.
- Normal frame (STABLE=4): en_in=110/sseg=0x3F, then 101/0x06, then 011/0x5B, 10 cycles each.
  - out0=0x3F, out1=0x06, out2=0x5B, each visible 6 cycles after its pin change.
  - digit_valid=111.
  - Exactly one frame_done pulse, 1 cycle after the out2 update.
- Glitch rejection: steady 110/0x3F captured, then en_in=101/0xFF for 2 cycles, then back to 110/0x3F -> out1 unchanged, no extra frame progress, no err_multi.
- Illegal enable: en_in=100 with sseg=0xAA held 10 cycles -> exactly one err_multi pulse, outputs and digit_valid unchanged. Repeat after en_in=111 -> second single pulse.
- Timeout (TIMEOUT_W=6): capture digit 0, then en_in=111 for 70 cycles.
  - timeout=1 from cycle 63 after the capture; digit_valid=000; out0 retained.
  - Next valid dwell on 101 -> timeout=0, out1 written, digit_valid=010.
- Sequence restart and reset: capture d0, d1, then d0 again, then d2 -> no frame_done (seen=101). Assert rst mid-dwell -> all state cleared, first capture only STABLE+2 cycles after release.
